// File: rtl/uart_tx_fifo.sv
// Parametrised RS-232 transmitter with an input FIFO and valid/ready handshake.
// Frames (start, LSB-first data, optional parity, stop bits) go out back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          send,
  output logic                          ready,
  output logic                          xmit_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam int CNT_W = $clog2(STOP_BITS * CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_END  = CNT_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic [FC_W-1:0]  FULL_CNT  = FC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Odd mode makes data plus parity hold an odd number of ones; even mode an even number.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    if (PARITY == 1) begin
      return ~(^word);
    end else begin
      return ^word;
    end
  endfunction

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [3:0]             idx_r, idx_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic                   par_r, par_s;
  logic                   xmit_r, xmit_s;
  logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [FC_W-1:0]        count_r, count_s;
  logic                   ready_r, busy_r;
  logic                   push_s, pop_s, tick_s;
  logic [DATA_BITS-1:0]   head_s;

  assign push_s     = send && ready_r;
  assign head_s     = mem_r[rd_ptr_r];
  assign ready      = ready_r;
  assign busy       = busy_r;
  assign xmit_data  = xmit_r;
  assign fifo_count = count_r;

  // Next-state, shift-register and line-level decode for the transmit FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1);
    idx_s   = idx_r;
    shift_s = shift_r;
    par_s   = par_r;
    xmit_s  = xmit_r;
    pop_s   = 1'b0;
    if (state_r == STOP) begin
      tick_s = (cnt_r == STOP_END);
    end else begin
      tick_s = (cnt_r == BIT_END);
    end
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (count_r != '0) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          par_s   = parity_bit(head_s);
          xmit_s  = 1'b0;
          state_s = START;
        end else begin
          xmit_s = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          cnt_s   = '0;
          xmit_s  = shift_r[0];
          shift_s = shift_r >> 1;
          idx_s   = 4'd0;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          cnt_s = '0;
          if (idx_r == LAST_IDX) begin
            if (PARITY != 0) begin
              xmit_s  = par_r;
              state_s = PAR;
            end else begin
              xmit_s  = 1'b1;
              state_s = STOP;
            end
          end else begin
            idx_s   = idx_r + 4'd1;
            xmit_s  = shift_r[0];
            shift_s = shift_r >> 1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PAR: begin
        if (tick_s) begin
          cnt_s   = '0;
          xmit_s  = 1'b1;
          state_s = STOP;
        end else begin
          state_s = PAR;
        end
      end
      STOP: begin
        if (tick_s) begin
          cnt_s = '0;
          // A queued word starts its frame on this very edge, so there is no mark gap.
          if (count_r != '0) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            par_s   = parity_bit(head_s);
            xmit_s  = 1'b0;
            state_s = START;
          end else begin
            xmit_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        cnt_s   = '0;
        xmit_s  = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy: a push and a pop on the same edge cancel out.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + FC_W'(1);
      2'b01:   count_s = count_r - FC_W'(1);
      default: count_s = count_r;
    endcase
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= 4'd0;
      shift_r  <= '0;
      par_r    <= 1'b0;
      xmit_r   <= 1'b1;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      par_r    <= par_s;
      xmit_r   <= xmit_s;
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r  <= count_s;
      ready_r  <= (count_s != FULL_CNT);
      busy_r   <= (state_s != IDLE) || (count_s != '0);
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule
